// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access controller.
// Size encodings, controller states and default memory depth.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEPTH_WORDS_DEF = 200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract (with sign/zero extend) and lane merge.
// Shared by the load path and the read-modify-write store path.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lo,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{lo, 3'b000} +: 8];
        h      = word[{lo[1], 4'b0000} +: 16];
        ldata  = word;
        merged = word;
        unique case (1'b1)
            size == SZ_BYTE: begin
                ldata = {{(DATA_W-8){sgn & b[7]}}, b};
                merged[{lo, 3'b000} +: 8] = wdata[7:0];
            end
            size == SZ_HALF: begin
                ldata = {{(DATA_W-16){sgn & h[15]}}, h};
                merged[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ldata  = word;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-addressed load/store front end for the word-addressed data memory.
// Sub-word stores go through read-modify-write; all outputs are registered.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] MemData
);

    state_t            state;
    logic [1:0]        lat_size;
    logic [1:0]        lat_lo;
    logic              lat_sgn;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] merged;
    logic              acc;
    logic              mis;
    logic              err_c;

    assign acc = req_valid & req_ready;

    always_comb begin
        mis = 1'b0;
        unique case (1'b1)
            req_size == SZ_BYTE: mis = 1'b0;
            req_size == SZ_HALF: mis = req_addr[0];
            req_size == SZ_WORD: mis = |req_addr[1:0];
            default:             mis = 1'b1;
        endcase
        err_c = mis | ((req_addr >> 2) >= DATA_W'(DEPTH_WORDS));
    end

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .word   (MemData),
        .lo     (lat_lo),
        .size   (lat_size),
        .sgn    (lat_sgn),
        .wdata  (lat_wdata),
        .ldata  (ldata),
        .merged (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Address    <= '0;
            WriteData  <= '0;
            lat_size   <= '0;
            lat_lo     <= '0;
            lat_sgn    <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (acc) begin
                        req_ready <= 1'b0;
                        lat_size  <= req_size;
                        lat_lo    <= req_addr[1:0];
                        lat_sgn   <= req_signed;
                        lat_wdata <= req_wdata;
                        if (err_c) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state   <= S_RD;
                            MemRead <= 1'b1;
                            Address <= req_addr >> 2;
                        end else if (req_size == SZ_WORD) begin
                            state     <= S_WR;
                            MemWrite  <= 1'b1;
                            Address   <= req_addr >> 2;
                            WriteData <= req_wdata;
                        end else begin
                            state   <= S_RMW_RD;
                            MemRead <= 1'b1;
                            Address <= req_addr >> 2;
                        end
                    end
                end
                S_RD: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ldata;
                end
                S_RMW_RD: begin
                    state     <= S_WR;
                    MemWrite  <= 1'b1;
                    WriteData <= merged;
                end
                S_WR: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    resp_err  <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
// Small word memory model; latency, strobes and data checked per scenario.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData;

    logic [31:0] mem [0:255];

    int errs = 0;
    int chk  = 0;
    int ovl  = 0;

    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] o_addr;
    logic [31:0] o_wd;
    logic [31:0] o_rd;
    logic        o_err;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemData    (MemData)
    );

    assign MemData = mem[Address[7:0]];

    always @(posedge clk) begin
        if (MemWrite) mem[Address[7:0]] <= WriteData;
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite) ovl++;
    end

    task automatic wait_ready();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd);
        wait_ready();
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        lat = 0; nrd = 0; nwr = 0;
        o_addr = 'x; o_wd = 'x; o_rd = 'x; o_err = 1'bx;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (MemRead) begin nrd++; o_addr = Address; end
            if (MemWrite) begin nwr++; o_addr = Address; o_wd = WriteData; end
            if (resp_valid) begin
                lat = k; o_rd = resp_rdata; o_err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk++;
        if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {req_ready, resp_valid, resp_err, MemRead, MemWrite});
        end
        chk++;
        if ({Address, WriteData, resp_rdata} !== 96'h0) begin
            errs++;
            $display("FAIL reset_data: got %h %h %h want 0", Address, WriteData, resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk++;
        if (req_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_word_load();
        mem[4] = 32'hDEADBEEF;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk++;
        if (lat !== 2 || nrd !== 1 || nwr !== 0) begin
            errs++;
            $display("FAIL wload_timing: got lat=%0d rd=%0d wr=%0d want 2 1 0", lat, nrd, nwr);
        end
        chk++;
        if (o_addr !== 32'd4) begin
            errs++;
            $display("FAIL wload_addr: got %h want 00000004", o_addr);
        end
        chk++;
        if (o_rd !== 32'hDEADBEEF || o_err !== 1'b0) begin
            errs++;
            $display("FAIL wload_data: got %h err=%b want deadbeef err=0", o_rd, o_err);
        end
        mem[199] = 32'hCAFE0199;
        do_req(1'b0, 2'b10, 1'b0, 32'h31C, 32'h0);
        chk++;
        if (o_rd !== 32'hCAFE0199 || o_err !== 1'b0 || lat !== 2) begin
            errs++;
            $display("FAIL wload_last: got %h err=%b lat=%0d want cafe0199 0 2", o_rd, o_err, lat);
        end
    endtask

    task automatic test_subword_load();
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic        sg [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'h000000FF, 32'hFFFF80FF};
        mem[4] = 32'h80FF0000;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], sg[i], ad[i], 32'h0);
            chk++;
            if (o_rd !== ex[i] || o_err !== 1'b0 || lat !== 2) begin
                errs++;
                $display("FAIL sload_%0d: got %h err=%b lat=%0d want %h 0 2",
                         i, o_rd, o_err, lat, ex[i]);
            end
        end
    endtask

    task automatic test_store();
        mem[2] = 32'hAAAABBBB;
        do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234);
        chk++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1) begin
            errs++;
            $display("FAIL hstore_timing: got lat=%0d rd=%0d wr=%0d want 3 1 1", lat, nrd, nwr);
        end
        chk++;
        if (o_wd !== 32'h1234BBBB || o_addr !== 32'd2) begin
            errs++;
            $display("FAIL hstore_data: got %h @%h want 1234bbbb @2", o_wd, o_addr);
        end
        chk++;
        if (o_rd !== 32'h0 || o_err !== 1'b0) begin
            errs++;
            $display("FAIL hstore_resp: got %h err=%b want 0 0", o_rd, o_err);
        end
        do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFFFFCD);
        chk++;
        if (mem[2] !== 32'h1234CDBB || lat !== 3) begin
            errs++;
            $display("FAIL bstore: got %h lat=%0d want 1234cdbb 3", mem[2], lat);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344);
        chk++;
        if (mem[3] !== 32'h11223344 || lat !== 2 || nrd !== 0 || nwr !== 1) begin
            errs++;
            $display("FAIL wstore: got %h lat=%0d rd=%0d wr=%0d want 11223344 2 0 1",
                     mem[3], lat, nrd, nwr);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h06, 32'h01, 32'h00, 32'h320};
        for (int i = 0; i < 4; i++) begin
            do_req(i[0], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
            chk++;
            if (lat !== 1 || o_err !== 1'b1 || o_rd !== 32'h0 || nrd !== 0 || nwr !== 0) begin
                errs++;
                $display("FAIL err_%0d: got lat=%0d err=%b rd=%h strb=%0d/%0d want 1 1 0 0/0",
                         i, lat, o_err, o_rd, nrd, nwr);
            end
        end
    endtask

    task automatic test_reset_in_wr();
        int rv;
        mem[5] = 32'h0;
        wait_ready();
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14;
        req_wdata = 32'h55555555; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk++;
        if (MemWrite !== 1'b1) begin
            errs++;
            $display("FAIL rst_wr_pre: got MemWrite=%b want 1", MemWrite);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk++;
        if (MemWrite !== 1'b0 || req_ready !== 1'b0) begin
            errs++;
            $display("FAIL rst_wr_async: got MemWrite=%b ready=%b want 0 0", MemWrite, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) rv++;
        end
        chk++;
        if (rv !== 0 || req_ready !== 1'b1 || mem[5] !== 32'h0) begin
            errs++;
            $display("FAIL rst_wr_post: got resp=%0d ready=%b mem=%h want 0 1 0",
                     rv, req_ready, mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1;
        int acc2 = -1;
        int rsp1 = -1;
        int rsp2 = -1;
        mem[7] = 32'h0BADF00D;
        mem[8] = 32'h0;
        wait_ready();
        req_write = 1'b0; req_size = 2'b10; req_addr = 32'h1C;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready && req_valid) begin
                if (acc1 < 0) acc1 = i;
                else if (acc2 < 0) acc2 = i;
            end
            @(posedge clk);
            #1;
            if (acc1 == i) begin
                req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h600DCAFE;
            end
            if (acc2 == i) req_valid = 1'b0;
            if (resp_valid) begin
                if (rsp1 < 0) begin
                    rsp1 = i;
                    chk++;
                    if (resp_rdata !== 32'h0BADF00D) begin
                        errs++;
                        $display("FAIL b2b_ldata: got %h want 0badf00d", resp_rdata);
                    end
                end else if (rsp2 < 0) rsp2 = i;
            end
        end
        req_valid = 1'b0;
        chk++;
        if (acc1 !== 0 || rsp1 !== 1 || acc2 !== 3 || rsp2 !== 4) begin
            errs++;
            $display("FAIL b2b_timing: got acc=%0d,%0d rsp=%0d,%0d want 0,3 1,4",
                     acc1, acc2, rsp1, rsp2);
        end
        chk++;
        if (mem[8] !== 32'h600DCAFE || ovl !== 0) begin
            errs++;
            $display("FAIL b2b_store: got %h overlap=%0d want 600dcafe 0", mem[8], ovl);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_word_load();
        test_subword_load();
        test_store();
        test_errors();
        test_reset_in_wr();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule
